// File: rtl/fp_acc_if.sv
// Operand/sum handshake bundle for the floating-point window accumulator.
interface fp_acc_if #(
    parameter int EW = 5,
    parameter int MW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exponent;
    logic [MW-1:0] in_mant;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [EW+MW:0] out_data;
    logic          out_overflow;

    modport master (
        output in_valid, in_sign, in_exponent, in_mant, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_mant, in_last, out_ready,
        output in_ready, out_valid, out_data, out_overflow
    );
endinterface

// File: rtl/fp_accumulator.sv
// Multi-cycle floating-point accumulator: sums each operand window and emits
// one truncated sum with a sticky saturation flag per window.
module fp_accumulator #(
    parameter int EXPONENT_WIDTH = 5,
    parameter int MANTISSA_WIDTH = 10
) (
    input  logic clk,
    input  logic rst_n,
    fp_acc_if.slave bus
);
    localparam int EW   = EXPONENT_WIDTH;
    localparam int MW   = MANTISSA_WIDTH;
    localparam int EMAX = (1 << EW) - 1;

    typedef enum logic [2:0] {ACCEPT, ALIGN, ADD, NORM, DONE} state_t;
    state_t state, state_nxt;

    logic          acc_sign, op_sign, a_sign, b_sign, op_last, ovf;
    logic [EW-1:0] acc_exp, op_exp, a_exp;
    logic [MW-1:0] acc_mant, op_mant;
    logic [MW:0]   a_mag, b_mag;
    logic [MW+1:0] sum;

    wire take = bus.in_valid && (state == ACCEPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCEPT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT: if (bus.in_valid) state_nxt = ALIGN;
            ALIGN:  state_nxt = ADD;
            ADD:    state_nxt = NORM;
            NORM:   state_nxt = op_last ? DONE : ACCEPT;
            DONE:   if (bus.out_ready) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    // Alignment: larger magnitude becomes A, smaller is shifted right with truncation.
    logic          op_big;
    logic [MW:0]   acc_mag, op_mag, small_mag;
    logic [EW-1:0] big_exp, small_exp, diff;
    always_comb begin
        acc_mag   = {acc_exp != '0, acc_mant};
        op_mag    = {op_exp != '0, op_mant};
        op_big    = {op_exp, op_mant} > {acc_exp, acc_mant};
        big_exp   = op_big ? op_exp : acc_exp;
        small_exp = op_big ? acc_exp : op_exp;
        small_mag = op_big ? acc_mag : op_mag;
        diff      = big_exp - small_exp;
    end

    // Normalisation with single-cycle leading-one search over the sum.
    int            lead, shift, n_exp;
    logic [MW:0]   norm_mag;
    logic [MW-1:0] n_mant;
    logic          n_zero, n_sat;
    always_comb begin
        lead = 0;
        for (int i = 0; i <= MW; i++)
            if (sum[i]) lead = i;
        shift    = MW - lead;
        norm_mag = sum[MW:0] << shift;
        if (sum[MW+1]) begin
            n_mant = sum[MW:1];
            n_exp  = int'(a_exp) + 1;
        end else begin
            n_mant = norm_mag[MW-1:0];
            n_exp  = int'(a_exp) - shift;
        end
        n_zero = (sum == '0) || (n_exp < 1);
        n_sat  = !n_zero && (n_exp >= EMAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sign <= 1'b0; acc_exp <= '0; acc_mant <= '0; ovf <= 1'b0;
            op_sign  <= 1'b0; op_exp  <= '0; op_mant  <= '0; op_last <= 1'b0;
            a_sign   <= 1'b0; a_exp   <= '0; a_mag    <= '0;
            b_sign   <= 1'b0; b_mag   <= '0; sum      <= '0;
        end else begin
            case (state)
                ACCEPT: if (take) begin
                    op_sign <= bus.in_sign;
                    op_last <= bus.in_last;
                    if (bus.in_exponent == EW'(EMAX)) begin
                        op_exp  <= EW'(EMAX - 1);
                        op_mant <= '1;
                        ovf     <= 1'b1;
                    end else if (bus.in_exponent == '0) begin
                        op_exp  <= '0;
                        op_mant <= '0;
                    end else begin
                        op_exp  <= bus.in_exponent;
                        op_mant <= bus.in_mant;
                    end
                end
                ALIGN: begin
                    a_sign <= op_big ? op_sign : acc_sign;
                    b_sign <= op_big ? acc_sign : op_sign;
                    a_exp  <= big_exp;
                    a_mag  <= op_big ? op_mag : acc_mag;
                    b_mag  <= (int'(diff) >= MW + 2) ? '0 : (small_mag >> diff);
                end
                ADD: sum <= (a_sign == b_sign) ? {1'b0, a_mag} + {1'b0, b_mag}
                                               : {1'b0, a_mag} - {1'b0, b_mag};
                NORM: begin
                    if (n_zero) begin
                        acc_sign <= 1'b0; acc_exp <= '0; acc_mant <= '0;
                    end else if (n_sat) begin
                        acc_sign <= a_sign; acc_exp <= EW'(EMAX - 1); acc_mant <= '1;
                        ovf      <= 1'b1;
                    end else begin
                        acc_sign <= a_sign; acc_exp <= n_exp[EW-1:0]; acc_mant <= n_mant;
                    end
                end
                DONE: if (bus.out_ready) begin
                    acc_sign <= 1'b0; acc_exp <= '0; acc_mant <= '0; ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // rst_n gating keeps the handshake closed while reset is held.
    assign bus.in_ready     = rst_n && (state == ACCEPT);
    assign bus.out_valid    = (state == DONE);
    assign bus.out_data     = (state == DONE) ? {acc_sign, acc_exp, acc_mant} : '0;
    assign bus.out_overflow = (state == DONE) && ovf;
endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: window sums, special values, backpressure, reset.
module tb_fp_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_acc_if #(.EW(5), .MW(10)) bus ();
    fp_accumulator #(.EXPONENT_WIDTH(5), .MANTISSA_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] sb[$];   // {overflow, data}

    task automatic send(input logic [15:0] v, input logic last);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sign = v[15]; bus.in_exponent = v[14:10];
        bus.in_mant = v[9:0]; bus.in_last = last;
        while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: operand %h not accepted, in_ready=%b want 1", v, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        ok = (n < 50);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_sign = 0; bus.in_exponent = 0; bus.in_mant = 0;
        bus.in_last = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_overflow, bus.out_data} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b ovf=%b data=%h want all 0",
                     bus.in_ready, bus.out_valid, bus.out_overflow, bus.out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    // Each entry is {last, operand}; expected sums are pushed when the last operand goes in.
    task automatic test_sum();
        logic [16:0] ops[11];
        logic [16:0] ex[5];
        logic [16:0] got, want;
        bit ok;
        int k = 0;
        ops = '{17'h0_3C00, 17'h0_4000, 17'h1_4200, 17'h0_3C00, 17'h1_3C00,
                17'h0_3C00, 17'h1_C000, 17'h0_3C00, 17'h1_1400, 17'h0_3C00, 17'h1_1000};
        ex  = '{17'h0_4600, 17'h0_4000, 17'h0_BC00, 17'h0_3C01, 17'h0_3C00};
        for (int i = 0; i < 11; i++) begin
            send(ops[i][15:0], ops[i][16]);
            if (ops[i][16]) begin
                sb.push_back(ex[k]); k++;
                wait_out(ok);
                got = {bus.out_overflow, bus.out_data}; want = sb.pop_front();
                vectors++;
                if (!ok || got !== want) begin
                    miscompares++;
                    $display("FAIL sum[%0d]: got ovf/data %h want %h (valid seen %b)", k, got, want, ok);
                end
                ack();
            end
        end
    endtask

    task automatic test_cancel();
        logic [16:0] ops[4];
        logic [16:0] ex[2];
        logic [16:0] got, want;
        bit ok;
        int k = 0;
        ops = '{17'h0_4500, 17'h1_C500, 17'h0_0600, 17'h1_8400};
        ex  = '{17'h0_0000, 17'h0_0000};
        for (int i = 0; i < 4; i++) begin
            send(ops[i][15:0], ops[i][16]);
            if (ops[i][16]) begin
                sb.push_back(ex[k]); k++;
                wait_out(ok);
                got = {bus.out_overflow, bus.out_data}; want = sb.pop_front();
                vectors++;
                if (!ok || got !== want) begin
                    miscompares++;
                    $display("FAIL cancel[%0d]: got ovf/data %h want %h (valid seen %b)", k, got, want, ok);
                end
                ack();
            end
        end
    endtask

    task automatic test_overflow();
        logic [16:0] ops[6];
        logic [16:0] ex[4];
        logic [16:0] got, want;
        bit ok;
        int k = 0;
        ops = '{17'h0_7BFF, 17'h1_7BFF, 17'h1_3C00, 17'h1_7C00, 17'h0_FBFF, 17'h1_FBFF};
        ex  = '{17'h1_7BFF, 17'h0_3C00, 17'h1_7BFF, 17'h1_FBFF};
        for (int i = 0; i < 6; i++) begin
            send(ops[i][15:0], ops[i][16]);
            if (ops[i][16]) begin
                sb.push_back(ex[k]); k++;
                wait_out(ok);
                got = {bus.out_overflow, bus.out_data}; want = sb.pop_front();
                vectors++;
                if (!ok || got !== want) begin
                    miscompares++;
                    $display("FAIL overflow[%0d]: got ovf/data %h want %h (valid seen %b)", k, got, want, ok);
                end
                ack();
            end
        end
    endtask

    task automatic test_subnormal();
        logic [16:0] ops[4];
        logic [16:0] ex[3];
        logic [16:0] got, want;
        bit ok;
        int k = 0;
        ops = '{17'h0_3C00, 17'h1_0011, 17'h1_2E66, 17'h1_0011};
        ex  = '{17'h0_3C00, 17'h0_2E66, 17'h0_0000};
        for (int i = 0; i < 4; i++) begin
            send(ops[i][15:0], ops[i][16]);
            if (ops[i][16]) begin
                sb.push_back(ex[k]); k++;
                wait_out(ok);
                got = {bus.out_overflow, bus.out_data}; want = sb.pop_front();
                vectors++;
                if (!ok || got !== want) begin
                    miscompares++;
                    $display("FAIL subnormal[%0d]: got ovf/data %h want %h (valid seen %b)", k, got, want, ok);
                end
                ack();
            end
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] got, want;
        bit ok;
        int n = 0;
        send(16'h3C00, 1'b1);
        sb.push_back(17'h0_3C00);
        // Next operand waits on the bus while the sum is stalled.
        bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exponent = 5'h10;
        bus.in_mant = 10'h0; bus.in_last = 1'b1;
        wait_out(ok);
        want = sb.pop_front();
        for (int c = 0; c < 6; c++) begin
            got = {bus.out_overflow, bus.out_data};
            vectors++;
            if (!ok || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got !== want) begin
                miscompares++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b ovf/data %h want vld=1 rdy=0 %h", c,
                         bus.out_valid, bus.in_ready, got, want);
            end
            @(negedge clk);
        end
        ack();
        while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(17'h0_4000);
        wait_out(ok);
        got = {bus.out_overflow, bus.out_data}; want = sb.pop_front();
        vectors++;
        if (!ok || got !== want) begin
            miscompares++;
            $display("FAIL held_operand: got ovf/data %h want %h (valid seen %b)", got, want, ok);
        end
        ack();
    endtask

    task automatic test_async_reset();
        logic [16:0] got, want;
        bit ok;
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        @(posedge clk); #1;          // now in ADD
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_overflow, bus.out_data} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset: got rdy=%b vld=%b ovf=%b data=%h want all 0",
                     bus.in_ready, bus.out_valid, bus.out_overflow, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h4000, 1'b1);
        sb.push_back(17'h0_4000);
        wait_out(ok);
        got = {bus.out_overflow, bus.out_data}; want = sb.pop_front();
        vectors++;
        if (!ok || got !== want) begin
            miscompares++;
            $display("FAIL post_reset_sum: got ovf/data %h want %h (valid seen %b)", got, want, ok);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_sum();
        test_cancel();
        test_overflow();
        test_subnormal();
        test_backpressure();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
